// File: rtl/pll_seq_pkg.sv
// Shared types, counter width and parameter defaults for the PLL reset sequencer.
package pll_seq_pkg;

    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    localparam int DEF_PLL_RST_CYC  = 16;
    localparam int DEF_LOCK_TIMEOUT = 50000;
    localparam int DEF_STABLE_CYC   = 4096;
    localparam int DEF_STAGGER_CYC  = 256;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [2:0] {
        S_PRST,
        S_WLOCK,
        S_STAB,
        S_REL,
        S_RUN
    } state_e;

    // Progress inside S_REL: all held (soft reset), video released, video+cpu released.
    typedef enum logic [1:0] {
        PH_HOLD,
        PH_VIDEO,
        PH_CPU
    } rel_phase_e;

    typedef struct packed {
        logic pll_rst;
        logic rst_video;
        logic rst_cpu;
        logic rst_audio;
        logic ready;
    } outs_t;

    localparam outs_t OUTS_RESET = '{pll_rst: 1'b1, rst_video: 1'b1, rst_cpu: 1'b1,
                                     rst_audio: 1'b1, ready: 1'b0};

    // Every cycle count must be non-zero and fit the shared counter.
    function automatic bit param_ok(input int value);
        return (value >= 1) && (value <= CNT_MAX);
    endfunction

    // Counter value seen in the last cycle of a phase lasting 'cycles' cycles.
    function automatic cnt_t last_count(input int cycles);
        return cnt_t'(cycles - 1);
    endfunction

endpackage

// File: rtl/pll_seq_sync.sv
// Two-flop synchronizer bringing the asynchronous PLL lock into the refclk domain.
module pll_seq_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the raw lock through two flops; both clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep this a true two-stage shift; blocking
            // would collapse meta and q into a single flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then releases
// the video, cpu and audio domain resets in a staggered order. Retries on timeout
// or lock loss and counts the retries.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYC  = DEF_PLL_RST_CYC,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYC   = DEF_STABLE_CYC,
    parameter int STAGGER_CYC  = DEF_STAGGER_CYC
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       soft_reset,
    output logic       pll_rst,
    output logic       rst_video,
    output logic       rst_cpu,
    output logic       rst_audio,
    output logic       ready,
    output logic [7:0] relock_count
);

    if (!param_ok(PLL_RST_CYC) || !param_ok(LOCK_TIMEOUT) ||
        !param_ok(STABLE_CYC)  || !param_ok(STAGGER_CYC)) begin : g_param_check
        $error("pll_reset_sequencer: every cycle parameter must lie in 1..%0d", CNT_MAX);
    end

    localparam cnt_t PRST_LAST    = last_count(PLL_RST_CYC);
    localparam cnt_t TIMEOUT_LAST = last_count(LOCK_TIMEOUT);
    localparam cnt_t STABLE_LAST  = last_count(STABLE_CYC);
    localparam cnt_t STAGGER_LAST = last_count(STAGGER_CYC);

    logic       lock_s;
    state_e     state, state_nx;
    rel_phase_e phase, phase_nx;
    cnt_t       cnt, cnt_nx;
    logic       relock_inc;
    outs_t      outs_q, outs_nx;

    pll_seq_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    // State, release phase and shared counter register.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state <= S_PRST;
            phase <= PH_HOLD;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state and counter decisions; lock loss always outranks soft reset.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_nx   = state;
        phase_nx   = phase;
        cnt_nx     = cnt + 1'b1;
        relock_inc = 1'b0;
        unique case (state)
            S_PRST: begin
                if (cnt == PRST_LAST) begin
                    state_nx = S_WLOCK;
                    cnt_nx   = '0;
                end
            end
            S_WLOCK: begin
                if (lock_s) begin
                    state_nx = S_STAB;
                    cnt_nx   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_nx   = S_PRST;
                    cnt_nx     = '0;
                    relock_inc = 1'b1;
                end
            end
            S_STAB: begin
                if (!lock_s) begin
                    state_nx = S_WLOCK;
                    cnt_nx   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nx = S_REL;
                    phase_nx = PH_VIDEO;
                    cnt_nx   = '0;
                end
            end
            S_REL, S_RUN: begin
                if (!lock_s) begin
                    state_nx   = S_PRST;
                    cnt_nx     = '0;
                    relock_inc = 1'b1;
                end else if (soft_reset) begin
                    state_nx = S_REL;
                    phase_nx = PH_HOLD;
                    cnt_nx   = '0;
                end else if (state == S_RUN) begin
                    cnt_nx = cnt;
                end else begin
                    unique case (phase)
                        PH_HOLD: begin
                            phase_nx = PH_VIDEO;
                            cnt_nx   = '0;
                        end
                        PH_VIDEO: begin
                            if (cnt == STAGGER_LAST) begin
                                phase_nx = PH_CPU;
                                cnt_nx   = '0;
                            end
                        end
                        PH_CPU: begin
                            if (cnt == STAGGER_LAST) begin
                                state_nx = S_RUN;
                                cnt_nx   = '0;
                            end
                        end
                        default: begin
                            phase_nx = PH_HOLD;
                            cnt_nx   = '0;
                        end
                    endcase
                end
            end
            default: begin
                state_nx = S_PRST;
                cnt_nx   = '0;
            end
        endcase
    end

    // Output values for the coming cycle, derived from where the FSM is going.
    always_comb begin
        outs_nx = '{pll_rst: 1'b0, rst_video: 1'b1, rst_cpu: 1'b1, rst_audio: 1'b1,
                    ready: 1'b0};
        unique case (state_nx)
            S_PRST: outs_nx.pll_rst = 1'b1;
            S_REL: begin
                outs_nx.rst_video = (phase_nx == PH_HOLD);
                outs_nx.rst_cpu   = (phase_nx != PH_CPU);
            end
            S_RUN: begin
                outs_nx.rst_video = 1'b0;
                outs_nx.rst_cpu   = 1'b0;
                outs_nx.rst_audio = 1'b0;
                outs_nx.ready     = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered outputs so every reset line is glitch-free.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            outs_q <= OUTS_RESET;
        end else begin
            outs_q <= outs_nx;
        end
    end

    // Saturating count of PLL reset re-attempts.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            relock_count <= '0;
        end else if (relock_inc && (relock_count != 8'hFF)) begin
            relock_count <= relock_count + 1'b1;
        end
    end

    assign pll_rst   = outs_q.pll_rst;
    assign rst_video = outs_q.rst_video;
    assign rst_cpu   = outs_q.rst_cpu;
    assign rst_audio = outs_q.rst_audio;
    assign ready     = outs_q.ready;

endmodule
